// File: rtl/calendar_pkg.sv
// Shared calendar arithmetic: weekday/month encodings, Gregorian leap rule,
// month lengths and a Zeller weekday function used by RTL and bench alike.
package calendar_pkg;

    localparam logic [2:0] SUN = 3'd0;
    localparam logic [2:0] MON = 3'd1;
    localparam logic [2:0] TUE = 3'd2;
    localparam logic [2:0] WED = 3'd3;
    localparam logic [2:0] THU = 3'd4;
    localparam logic [2:0] FRI = 3'd5;
    localparam logic [2:0] SAT = 3'd6;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_FWD,
        OP_BWD,
        OP_SET
    } op_e;

    function automatic logic is_leap(input logic [31:0] y);
        return ((y % 32'd4) == 32'd0) &&
               (((y % 32'd100) != 32'd0) || ((y % 32'd400) == 32'd0));
    endfunction

    function automatic logic [4:0] days_in_month(input logic [31:0] y, input logic [3:0] m);
        logic [4:0] n;
        n = 5'd0;
        case (m)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: n = 5'd31;
            APR, JUN, SEP, NOV:                n = 5'd30;
            FEB:                               n = is_leap(y) ? 5'd29 : 5'd28;
            default:                           n = 5'd0;
        endcase
        return n;
    endfunction

    // Zeller with a +400 year bias (weekday-neutral) so Jan/Feb of year 0 cannot underflow.
    function automatic logic [2:0] weekday(input logic [31:0] y, input logic [3:0] m,
                                           input logic [4:0] d);
        logic [31:0] yy;
        logic [31:0] mm;
        logic [31:0] k;
        logic [31:0] j;
        logic [31:0] h;
        logic [2:0]  w;
        if (m < MAR) begin
            mm = 32'(m) + 32'd12;
            yy = y + 32'd399;
        end else begin
            mm = 32'(m);
            yy = y + 32'd400;
        end
        k = yy % 32'd100;
        j = yy / 32'd100;
        h = (32'(d) + (32'd13 * (mm + 32'd1)) / 32'd5 + k + k / 32'd4 + j / 32'd4
             + 32'd5 * j) % 32'd7;
        case (h[2:0])
            3'd0:    w = SAT;
            3'd1:    w = SUN;
            3'd2:    w = MON;
            3'd3:    w = TUE;
            3'd4:    w = WED;
            3'd5:    w = THU;
            default: w = FRI;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/calendar_counter_if.sv
// Control/status bundle between the calendar counter and its neighbours.
interface calendar_counter_if #(
    parameter int YEAR_W = 14
);
    logic              en_day;
    logic              dn_day;
    logic              set_date;
    logic [YEAR_W+8:0] bin_date;
    logic [YEAR_W-1:0] year;
    logic [3:0]        month;
    logic [4:0]        day;
    logic [2:0]        week;
    logic [4:0]        max_date;
    logic              leap_year;
    logic              set_err;
    logic              wrap;

    modport master (
        output en_day, dn_day, set_date, bin_date,
        input  year, month, day, week, max_date, leap_year, set_err, wrap
    );

    modport slave (
        input  en_day, dn_day, set_date, bin_date,
        output year, month, day, week, max_date, leap_year, set_err, wrap
    );
endinterface

// File: rtl/calendar_weekday.sv
// Combinational weekday of a packed {year, month, day} word; shared by the
// date-load path and the alarm block.
module calendar_weekday
    import calendar_pkg::*;
#(
    parameter int YEAR_W = 14
) (
    input  logic [YEAR_W+8:0] bin_date,
    output logic [2:0]        week
);
    assign week = weekday(32'(bin_date[YEAR_W+8:9]), bin_date[8:5], bin_date[4:0]);
endmodule

// File: rtl/calendar_counter.sv
// Year/month/day register stepping one day forward or back per strobe, with a
// validated load path, incremental weekday and wrap inside [MIN_YEAR, MAX_YEAR].
module calendar_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_W   = 14,
    parameter int MIN_YEAR = 1,
    parameter int MAX_YEAR = 9999
) (
    input  logic               clk,
    input  logic               rst,
    calendar_counter_if.slave  bus
);
    localparam logic [YEAR_W-1:0] MIN_Y    = YEAR_W'(MIN_YEAR);
    localparam logic [YEAR_W-1:0] MAX_Y    = YEAR_W'(MAX_YEAR);
    localparam logic [YEAR_W-1:0] ONE_Y    = YEAR_W'(1);
    localparam logic [2:0]        WEEK_MIN = weekday(32'(MIN_YEAR), JAN, 5'd1);
    localparam logic [2:0]        WEEK_MAX = weekday(32'(MAX_YEAR), DEC, 5'd31);

    logic [YEAR_W-1:0] year_q, year_d;
    logic [3:0]        month_q, month_d;
    logic [4:0]        day_q, day_d;
    logic [2:0]        week_q, week_d;
    logic              set_err_q, set_err_d;
    logic              wrap_q, wrap_d;

    logic [YEAR_W-1:0] in_year;
    logic [3:0]        in_month;
    logic [4:0]        in_day;
    logic [4:0]        in_max;
    logic [2:0]        in_week;
    logic              in_valid;
    logic [4:0]        cur_max;
    logic [4:0]        prev_max;
    op_e               op;

    assign in_year  = bus.bin_date[YEAR_W+8:9];
    assign in_month = bus.bin_date[8:5];
    assign in_day   = bus.bin_date[4:0];

    calendar_weekday #(
        .YEAR_W (YEAR_W)
    ) u_weekday (
        .bin_date (bus.bin_date),
        .week     (in_week)
    );

    // Month length of the incoming year, so loads into Feb 29 follow the new year.
    assign in_max   = days_in_month(32'(in_year), in_month);
    assign in_valid = (in_year >= MIN_Y) && (in_year <= MAX_Y) &&
                      (in_month >= JAN) && (in_month <= DEC) &&
                      (in_day != 5'd0) && (in_day <= in_max);

    assign cur_max  = days_in_month(32'(year_q), month_q);
    assign prev_max = days_in_month(32'(year_q), month_q - 4'd1);

    always_comb begin
        op = OP_HOLD;
        if (bus.set_date) begin
            op = OP_SET;
        end else if (bus.en_day && !bus.dn_day) begin
            op = OP_FWD;
        end else if (bus.dn_day && !bus.en_day) begin
            op = OP_BWD;
        end
    end

    always_comb begin
        year_d    = year_q;
        month_d   = month_q;
        day_d     = day_q;
        week_d    = week_q;
        set_err_d = 1'b0;
        wrap_d    = 1'b0;
        case (op)
            OP_SET: begin
                if (in_valid) begin
                    year_d  = in_year;
                    month_d = in_month;
                    day_d   = in_day;
                    week_d  = in_week;
                end else begin
                    set_err_d = 1'b1;
                end
            end
            OP_FWD: begin
                week_d = (week_q == SAT) ? SUN : week_q + 3'd1;
                if (day_q < cur_max) begin
                    day_d = day_q + 5'd1;
                end else if (month_q < DEC) begin
                    month_d = month_q + 4'd1;
                    day_d   = 5'd1;
                end else if (year_q < MAX_Y) begin
                    year_d  = year_q + ONE_Y;
                    month_d = JAN;
                    day_d   = 5'd1;
                end else begin
                    year_d  = MIN_Y;
                    month_d = JAN;
                    day_d   = 5'd1;
                    week_d  = WEEK_MIN;
                    wrap_d  = 1'b1;
                end
            end
            OP_BWD: begin
                week_d = (week_q == SUN) ? SAT : week_q - 3'd1;
                if (day_q > 5'd1) begin
                    day_d = day_q - 5'd1;
                end else if (month_q > JAN) begin
                    month_d = month_q - 4'd1;
                    day_d   = prev_max;
                end else if (year_q > MIN_Y) begin
                    year_d  = year_q - ONE_Y;
                    month_d = DEC;
                    day_d   = 5'd31;
                end else begin
                    year_d  = MAX_Y;
                    month_d = DEC;
                    day_d   = 5'd31;
                    week_d  = WEEK_MAX;
                    wrap_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            year_q    <= MIN_Y;
            month_q   <= JAN;
            day_q     <= 5'd1;
            week_q    <= WEEK_MIN;
            set_err_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            year_q    <= year_d;
            month_q   <= month_d;
            day_q     <= day_d;
            week_q    <= week_d;
            set_err_q <= set_err_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.year      = year_q;
    assign bus.month     = month_q;
    assign bus.day       = day_q;
    assign bus.week      = week_q;
    assign bus.max_date  = cur_max;
    assign bus.leap_year = is_leap(32'(year_q));
    assign bus.set_err   = set_err_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_calendar_counter.sv
// Scoreboard bench for calendar_counter: directed calendar edge cases plus
// random day-step streams checked against a reference date model.
module tb_calendar_counter;
    import calendar_pkg::*;

    localparam int YW = 14;

    typedef struct packed {
        logic [YW-1:0] y;
        logic [3:0]    m;
        logic [4:0]    d;
        logic [2:0]    w;
        logic [4:0]    mx;
        logic          lp;
        logic          se;
        logic          wr;
    } snap_t;

    typedef struct {
        logic          en;
        logic          dn;
        logic          st;
        logic [YW+8:0] bin;
        logic          hw;
        logic [2:0]    kw;
        logic          hd;
        logic [YW+8:0] kd;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    calendar_counter_if #(.YEAR_W(YW)) bus ();

    calendar_counter #(
        .YEAR_W   (YW),
        .MIN_YEAR (1),
        .MAX_YEAR (9999)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    snap_t sb[$];
    logic [YW-1:0] cur_y;
    logic [3:0]    cur_m;
    logic [4:0]    cur_d;

    function automatic logic [YW+8:0] pk(input int y, input int m, input int d);
        return {YW'(y), 4'(m), 5'(d)};
    endfunction

    function automatic stim_t S(input logic en, input logic dn, input logic st,
                                input logic [YW+8:0] bin, input logic hw,
                                input logic [2:0] kw, input logic hd,
                                input logic [YW+8:0] kd);
        stim_t s;
        s.en = en; s.dn = dn; s.st = st; s.bin = bin;
        s.hw = hw; s.kw = kw; s.hd = hd; s.kd = kd;
        return s;
    endfunction

    function automatic snap_t observe();
        snap_t o;
        o.y = bus.year; o.m = bus.month; o.d = bus.day; o.w = bus.week;
        o.mx = bus.max_date; o.lp = bus.leap_year; o.se = bus.set_err; o.wr = bus.wrap;
        return o;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("%0d-%0d-%0d w%0d max%0d leap%0d se%0d wrap%0d",
                         s.y, s.m, s.d, s.w, s.mx, s.lp, s.se, s.wr);
    endfunction

    function automatic snap_t reset_snap();
        snap_t s;
        s.y = 14'd1; s.m = 4'd1; s.d = 5'd1; s.w = 3'd1;
        s.mx = 5'd31; s.lp = 1'b0; s.se = 1'b0; s.wr = 1'b0;
        return s;
    endfunction

    task automatic model(input stim_t s);
        snap_t e;
        logic [YW-1:0] y;
        logic [3:0] m;
        logic [4:0] d;
        e = '0;
        if (s.st) begin
            y = s.bin[YW+8:9]; m = s.bin[8:5]; d = s.bin[4:0];
            if (y >= 14'd1 && y <= 14'd9999 && m >= 4'd1 && m <= 4'd12 &&
                d >= 5'd1 && d <= days_in_month(32'(y), m)) begin
                cur_y = y; cur_m = m; cur_d = d;
            end else begin
                e.se = 1'b1;
            end
        end else if (s.en && !s.dn) begin
            if (cur_d < days_in_month(32'(cur_y), cur_m)) cur_d = cur_d + 5'd1;
            else if (cur_m < 4'd12) begin cur_m = cur_m + 4'd1; cur_d = 5'd1; end
            else if (cur_y < 14'd9999) begin cur_y = cur_y + 14'd1; cur_m = 4'd1; cur_d = 5'd1; end
            else begin cur_y = 14'd1; cur_m = 4'd1; cur_d = 5'd1; e.wr = 1'b1; end
        end else if (s.dn && !s.en) begin
            if (cur_d > 5'd1) cur_d = cur_d - 5'd1;
            else if (cur_m > 4'd1) begin
                cur_m = cur_m - 4'd1;
                cur_d = days_in_month(32'(cur_y), cur_m);
            end
            else if (cur_y > 14'd1) begin cur_y = cur_y - 14'd1; cur_m = 4'd12; cur_d = 5'd31; end
            else begin cur_y = 14'd9999; cur_m = 4'd12; cur_d = 5'd31; e.wr = 1'b1; end
        end
        e.y = cur_y; e.m = cur_m; e.d = cur_d;
        e.w = weekday(32'(cur_y), cur_m, cur_d);
        e.mx = days_in_month(32'(cur_y), cur_m);
        e.lp = is_leap(32'(cur_y));
        sb.push_back(e);
    endtask

    // Called at posedge+1; drives for one cycle and returns at the next posedge+1.
    task automatic step(input stim_t s);
        bus.en_day = s.en; bus.dn_day = s.dn; bus.set_date = s.st; bus.bin_date = s.bin;
        model(s);
        @(posedge clk); #1;
        bus.en_day = 1'b0; bus.dn_day = 1'b0; bus.set_date = 1'b0;
    endtask

    task automatic test_reset();
        snap_t o;
        snap_t e;
        rst = 1'b0;
        bus.en_day = 1'b0; bus.dn_day = 1'b0; bus.set_date = 1'b0; bus.bin_date = '0;
        #12;
        sb.push_back(reset_snap());
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_hold: got %s want %s", fmt(o), fmt(e)); end
        @(negedge clk); rst = 1'b1;
        cur_y = 14'd1; cur_m = 4'd1; cur_d = 5'd1;
        @(posedge clk); #1;
        sb.push_back(reset_snap());
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_release: got %s want %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_leap();
        stim_t t[$];
        snap_t o, e;
        t.push_back(S(0, 0, 1, pk(2024, 2, 28), 1, 3'd3, 0, '0));
        t.push_back(S(1, 0, 0, '0, 1, 3'd4, 1, pk(2024, 2, 29)));
        t.push_back(S(1, 0, 0, '0, 1, 3'd5, 1, pk(2024, 3, 1)));
        t.push_back(S(0, 0, 1, pk(1900, 2, 28), 0, '0, 1, pk(1900, 2, 28)));
        t.push_back(S(1, 0, 0, '0, 0, '0, 1, pk(1900, 3, 1)));
        foreach (t[i]) begin
            step(t[i]);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL leap[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
            if (t[i].hw) begin
                checks++;
                if (o.w !== t[i].kw) begin errors++; $display("FAIL leap_week[%0d]: got %0d want %0d", i, o.w, t[i].kw); end
            end
            if (t[i].hd) begin
                checks++;
                if ({o.y, o.m, o.d} !== t[i].kd) begin errors++; $display("FAIL leap_date[%0d]: got %0d-%0d-%0d want %h", i, o.y, o.m, o.d, t[i].kd); end
            end
        end
    endtask

    task automatic test_validation();
        stim_t t[$];
        snap_t o, e;
        t.push_back(S(0, 0, 1, pk(2024, 2, 28), 0, '0, 0, '0));
        t.push_back(S(0, 0, 1, pk(2023, 2, 29), 0, '0, 1, pk(2024, 2, 28)));
        t.push_back(S(0, 0, 0, '0, 0, '0, 1, pk(2024, 2, 28)));
        t.push_back(S(0, 0, 1, pk(2000, 2, 29), 1, 3'd2, 1, pk(2000, 2, 29)));
        t.push_back(S(0, 0, 1, pk(2000, 13, 1), 0, '0, 1, pk(2000, 2, 29)));
        t.push_back(S(0, 0, 1, pk(2000, 1, 0), 0, '0, 1, pk(2000, 2, 29)));
        t.push_back(S(0, 0, 1, pk(0, 1, 1), 0, '0, 1, pk(2000, 2, 29)));
        t.push_back(S(0, 0, 1, pk(10000, 1, 1), 0, '0, 1, pk(2000, 2, 29)));
        t.push_back(S(0, 0, 1, pk(2023, 4, 31), 0, '0, 1, pk(2000, 2, 29)));
        foreach (t[i]) begin
            step(t[i]);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL valid[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
            if (t[i].hw) begin
                checks++;
                if (o.w !== t[i].kw) begin errors++; $display("FAIL valid_week[%0d]: got %0d want %0d", i, o.w, t[i].kw); end
            end
            if (t[i].hd) begin
                checks++;
                if ({o.y, o.m, o.d} !== t[i].kd) begin errors++; $display("FAIL valid_date[%0d]: got %0d-%0d-%0d want %h", i, o.y, o.m, o.d, t[i].kd); end
            end
        end
    endtask

    task automatic test_wrap();
        stim_t t[$];
        snap_t o, e;
        t.push_back(S(0, 0, 1, pk(9999, 12, 31), 1, 3'd5, 0, '0));
        t.push_back(S(1, 0, 0, '0, 1, 3'd1, 1, pk(1, 1, 1)));
        t.push_back(S(0, 0, 0, '0, 0, '0, 0, '0));
        t.push_back(S(0, 1, 0, '0, 1, 3'd5, 1, pk(9999, 12, 31)));
        t.push_back(S(0, 0, 0, '0, 0, '0, 0, '0));
        foreach (t[i]) begin
            step(t[i]);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL wrap[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
            if (t[i].hw) begin
                checks++;
                if (o.w !== t[i].kw) begin errors++; $display("FAIL wrap_week[%0d]: got %0d want %0d", i, o.w, t[i].kw); end
            end
            if (t[i].hd) begin
                checks++;
                if ({o.y, o.m, o.d} !== t[i].kd) begin errors++; $display("FAIL wrap_date[%0d]: got %0d-%0d-%0d want %h", i, o.y, o.m, o.d, t[i].kd); end
            end
        end
    endtask

    task automatic test_backward();
        stim_t t[$];
        snap_t o, e;
        t.push_back(S(0, 0, 1, pk(2024, 3, 1), 1, 3'd5, 0, '0));
        t.push_back(S(0, 1, 0, '0, 1, 3'd4, 1, pk(2024, 2, 29)));
        t.push_back(S(0, 0, 1, pk(2023, 1, 1), 1, 3'd0, 0, '0));
        t.push_back(S(0, 1, 0, '0, 1, 3'd6, 1, pk(2022, 12, 31)));
        t.push_back(S(0, 1, 0, '0, 1, 3'd5, 1, pk(2022, 12, 30)));
        foreach (t[i]) begin
            step(t[i]);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL back[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
            if (t[i].hw) begin
                checks++;
                if (o.w !== t[i].kw) begin errors++; $display("FAIL back_week[%0d]: got %0d want %0d", i, o.w, t[i].kw); end
            end
            if (t[i].hd) begin
                checks++;
                if ({o.y, o.m, o.d} !== t[i].kd) begin errors++; $display("FAIL back_date[%0d]: got %0d-%0d-%0d want %h", i, o.y, o.m, o.d, t[i].kd); end
            end
        end
    endtask

    task automatic test_simultaneous();
        stim_t t[$];
        snap_t o, e;
        t.push_back(S(1, 0, 1, pk(2024, 6, 15), 0, '0, 1, pk(2024, 6, 15)));
        t.push_back(S(0, 1, 1, pk(2024, 6, 20), 0, '0, 1, pk(2024, 6, 20)));
        t.push_back(S(1, 1, 0, '0, 0, '0, 1, pk(2024, 6, 20)));
        foreach (t[i]) begin
            step(t[i]);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL simul[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
            if (t[i].hd) begin
                checks++;
                if ({o.y, o.m, o.d} !== t[i].kd) begin errors++; $display("FAIL simul_date[%0d]: got %0d-%0d-%0d want %h", i, o.y, o.m, o.d, t[i].kd); end
            end
        end
        bus.en_day = 1'b1;
        #2 rst = 1'b0;
        #1;
        sb.push_back(reset_snap());
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_midstep: got %s want %s", fmt(o), fmt(e)); end
        @(posedge clk); #1;
        sb.push_back(reset_snap());
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_edge: got %s want %s", fmt(o), fmt(e)); end
        bus.en_day = 1'b0;
        rst = 1'b1;
        cur_y = 14'd1; cur_m = 4'd1; cur_d = 5'd1;
    endtask

    task automatic test_random();
        snap_t o, e;
        stim_t s;
        int y, m, d;
        for (int r = 0; r < 20; r++) begin
            case ($urandom_range(0, 3))
                0:       begin y = 1;    m = 1;  end
                1:       begin y = 9999; m = 12; end
                default: begin y = int'($urandom_range(1, 9999)); m = int'($urandom_range(1, 12)); end
            endcase
            d = int'($urandom_range(1, int'(days_in_month(32'(y), 4'(m)))));
            step(S(0, 0, 1, pk(y, m, d), 0, '0, 0, '0));
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL rand_set[%0d]: got %s want %s", r, fmt(o), fmt(e)); end
            for (int k = 0; k < 500; k++) begin
                case ($urandom_range(0, 9))
                    0:       s = S(1, 1, 0, '0, 0, '0, 0, '0);
                    1:       s = S(0, 0, 0, '0, 0, '0, 0, '0);
                    2, 3, 4, 5: s = S(1, 0, 0, '0, 0, '0, 0, '0);
                    default: s = S(0, 1, 0, '0, 0, '0, 0, '0);
                endcase
                step(s);
                e = sb.pop_front(); o = observe(); checks++;
                if (o !== e) begin errors++; $display("FAIL rand[%0d.%0d]: got %s want %s", r, k, fmt(o), fmt(e)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_leap();
        test_validation();
        test_wrap();
        test_backward();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
